// File: rtl/coin_pkg.sv
// coin_pkg
// Shared definitions for the coin dispenser slice: the FSM state encoding,
// the coin-type codes and a helper that sizes the pulse/gap timer.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        HALF = 1'b0,
        ONE  = 1'b1
    } coin_t;

    // Timer width needed to hold the larger of the pulse and gap lengths.
    function automatic int timer_width(input int pulse_len, input int gap_len);
        int longest;
        longest = (pulse_len > gap_len) ? pulse_len : gap_len;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// coin_pulse_timer
// Loadable down-counter that times both the coin pulse high phase and the
// following low gap. Loading N-1 makes tc rise on the Nth cycle after the load.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         asynchronous active-high reset, clears the count
//   load        load load_value on the next edge (has priority over counting)
//   load_value  value to load
//   tc          terminal count, high while the count is zero
module coin_pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/coin_dispense.sv
// coin_dispense
// Turns a change amount (half-yen units) into a train of coin pulses for a
// dispenser: all one-yen coins first, then one half-yen coin if the amount is
// odd. Each pulse is PULSE_CYCLES high followed by GAP_CYCLES low; a completion
// strobe (done) closes the request, qualified by aborted.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   req_valid    change request present
//   req_amount   change to dispense, half-yen units (AMT_W bits)
//   req_ready    high in IDLE only (held low during reset)
//   abort        stop after the pulse in flight and its gap
//   hf_out       registered half-yen coin pulse
//   one_out      registered one-yen coin pulse
//   busy         request in progress (PULSE, GAP, DONE)
//   done         one-cycle completion strobe
//   aborted      high with done when the request ended by abort
module coin_dispense
    import coin_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int AMT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             abort,
    output logic             hf_out,
    output logic             one_out,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int TIMER_W = timer_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [AMT_W-2:0]   ONE_STEP   = {{(AMT_W-2){1'b0}}, 1'b1};

    state_t             state, state_next;
    coin_t              coin, coin_next;
    logic [AMT_W-2:0]   one_cnt, one_cnt_next;
    logic               hf_cnt, hf_cnt_next;
    logic               abort_pending, abort_pending_next;
    logic               aborted_next;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_tc;

    coin_pulse_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    // State, counters and the registered coin outputs. The coin outputs are
    // decoded from the next state so each pulse lines up exactly with PULSE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            coin          <= ONE;
            one_cnt       <= '0;
            hf_cnt        <= 1'b0;
            abort_pending <= 1'b0;
            aborted       <= 1'b0;
            one_out       <= 1'b0;
            hf_out        <= 1'b0;
        end else begin
            state         <= state_next;
            coin          <= coin_next;
            one_cnt       <= one_cnt_next;
            hf_cnt        <= hf_cnt_next;
            abort_pending <= abort_pending_next;
            aborted       <= aborted_next;
            one_out       <= (state_next == PULSE) && (coin_next == ONE);
            hf_out        <= (state_next == PULSE) && (coin_next == HALF);
        end
    end

    // Next-state logic. A coin counter is consumed when its pulse ends, so at
    // the end of a gap the remaining counts say whether another pulse follows.
    // An abort seen in PULSE or GAP is remembered and only acted on when the
    // gap finishes, so a pulse is never cut short.
    always_comb begin
        state_next         = state;
        coin_next          = coin;
        one_cnt_next       = one_cnt;
        hf_cnt_next        = hf_cnt;
        abort_pending_next = abort_pending;
        aborted_next       = 1'b0;
        timer_load         = 1'b0;
        timer_value        = PULSE_LOAD;

        case (state)
            IDLE: begin
                abort_pending_next = 1'b0;
                if (req_valid) begin
                    one_cnt_next = req_amount[AMT_W-1:1];
                    hf_cnt_next  = req_amount[0];
                    if (req_amount == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next  = PULSE;
                        timer_load  = 1'b1;
                        timer_value = PULSE_LOAD;
                        coin_next   = (req_amount[AMT_W-1:1] != '0) ? ONE : HALF;
                    end
                end
            end

            PULSE: begin
                if (abort) begin
                    abort_pending_next = 1'b1;
                end
                if (timer_tc) begin
                    state_next  = GAP;
                    timer_load  = 1'b1;
                    timer_value = GAP_LOAD;
                    if (coin == ONE) begin
                        one_cnt_next = one_cnt - ONE_STEP;
                    end else begin
                        hf_cnt_next = 1'b0;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    abort_pending_next = 1'b1;
                end
                if (timer_tc) begin
                    if (abort_pending || abort) begin
                        state_next   = DONE;
                        aborted_next = 1'b1;
                    end else if (one_cnt != '0) begin
                        state_next  = PULSE;
                        timer_load  = 1'b1;
                        timer_value = PULSE_LOAD;
                        coin_next   = ONE;
                    end else if (hf_cnt) begin
                        state_next  = PULSE;
                        timer_load  = 1'b1;
                        timer_value = PULSE_LOAD;
                        coin_next   = HALF;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                state_next         = IDLE;
                abort_pending_next = 1'b0;
                one_cnt_next       = '0;
                hf_cnt_next        = 1'b0;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // req_ready is gated by rst so it reads low for the whole reset window.
    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_coin_dispense.sv
// tb_coin_dispense
// Directed bench for coin_dispense with PULSE_CYCLES=4, GAP_CYCLES=4.
// Outputs are sampled on the falling edge as the word
// {req_ready, busy, done, aborted, hf_out, one_out}.
module tb_coin_dispense;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [5:0] req_amount = '0;
    logic       abort = 1'b0;
    logic       req_ready;
    logic       hf_out;
    logic       one_out;
    logic       busy;
    logic       done;
    logic       aborted;

    int vectors = 0;
    int miscompares = 0;

    logic [5:0] obs;
    logic [5:0] cap [0:31];

    coin_dispense #(
        .PULSE_CYCLES (4),
        .GAP_CYCLES   (4),
        .AMT_W        (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .abort      (abort),
        .hf_out     (hf_out),
        .one_out    (one_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    assign obs = {req_ready, busy, done, aborted, hf_out, one_out};

    // Offers one request in cycle 0 and records the output word for cycles
    // 0..n. abort is raised for the single cycle abort_cyc (-1 for none).
    task automatic capture_request(input logic [5:0] amt, input int abort_cyc, input int n);
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = amt;
        abort      = (abort_cyc == 0);
        cap[0]     = obs;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_amount = 6'h3F;
            abort      = (k == abort_cyc);
            cap[k]     = obs;
        end
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %b want %b", obs, 6'b000000);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== 6'b100000) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %b want %b", obs, 6'b100000);
        end
    endtask

    task automatic test_amount_three;
        logic [5:0] exp;
        capture_request(6'd3, -1, 20);
        for (int k = 0; k <= 20; k++) begin
            exp = {(k == 0 || k >= 18), (k >= 1 && k <= 17), (k == 17), 1'b0,
                   (k >= 9 && k <= 12), (k >= 1 && k <= 4)};
            vectors++;
            if (cap[k] !== exp) begin
                miscompares++;
                $display("[TB] FAIL amount3 cycle %0d: got %b want %b", k, cap[k], exp);
            end
        end
    endtask

    task automatic test_amount_four;
        logic [5:0] exp;
        capture_request(6'd4, -1, 20);
        for (int k = 0; k <= 20; k++) begin
            exp = {(k == 0 || k >= 18), (k >= 1 && k <= 17), (k == 17), 1'b0,
                   1'b0, ((k >= 1 && k <= 4) || (k >= 9 && k <= 12))};
            vectors++;
            if (cap[k] !== exp) begin
                miscompares++;
                $display("[TB] FAIL amount4 cycle %0d: got %b want %b", k, cap[k], exp);
            end
        end
    endtask

    // Zero amount; abort offered in the IDLE cycle must be ignored.
    task automatic test_amount_zero;
        logic [5:0] exp;
        capture_request(6'd0, 0, 4);
        for (int k = 0; k <= 4; k++) begin
            exp = {(k == 0 || k >= 2), (k == 1), (k == 1), 1'b0, 1'b0, 1'b0};
            vectors++;
            if (cap[k] !== exp) begin
                miscompares++;
                $display("[TB] FAIL amount0 cycle %0d: got %b want %b", k, cap[k], exp);
            end
        end
    endtask

    task automatic test_abort;
        logic [5:0] exp;
        capture_request(6'd6, 2, 14);
        for (int k = 0; k <= 14; k++) begin
            exp = {(k == 0 || k >= 10), (k >= 1 && k <= 9), (k == 9), (k == 9),
                   1'b0, (k >= 1 && k <= 4)};
            vectors++;
            if (cap[k] !== exp) begin
                miscompares++;
                $display("[TB] FAIL abort6 cycle %0d: got %b want %b", k, cap[k], exp);
            end
        end
    endtask

    task automatic test_reset_midpulse;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 6'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== 6'b010001) begin
            miscompares++;
            $display("[TB] FAIL midpulse_before: got %b want %b", obs, 6'b010001);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL midpulse_async: got %b want %b", obs, 6'b000000);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (obs !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL midpulse_held: got %b want %b", obs, 6'b000000);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== 6'b100000) begin
            miscompares++;
            $display("[TB] FAIL midpulse_release: got %b want %b", obs, 6'b100000);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 6'b100000) begin
                miscompares++;
                $display("[TB] FAIL midpulse_discard cycle %0d: got %b want %b", k, obs, 6'b100000);
            end
        end
    endtask

    // Amount 1 then amount 2 with req_valid held high throughout.
    task automatic test_back_to_back;
        logic [5:0] exp;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 6'd1;
        cap[0]     = obs;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            req_amount = 6'd2;
            if (k == 11) begin
                req_valid = 1'b0;
            end
            cap[k] = obs;
        end
        req_valid = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            exp = {(k == 0 || k == 10 || k >= 20),
                   ((k >= 1 && k <= 9) || (k >= 11 && k <= 19)),
                   (k == 9 || k == 19), 1'b0,
                   (k >= 1 && k <= 4), (k >= 11 && k <= 14)};
            vectors++;
            if (cap[k] !== exp) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b want %b", k, cap[k], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_amount_three();
        test_amount_four();
        test_amount_zero();
        test_abort();
        test_reset_midpulse();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
